// File: rtl/spi_pkg.sv
// Shared SPI definitions for the monarch and serf blocks.
// Frame width, serf state encoding and counter sizing helper.
package spi_pkg;

   localparam int SPI_DATA_W = 16;

   typedef enum logic {IDLE, SHIFT} serf_state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/spi_serf_sync_ff.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
// RST_VAL sets the idle level the chain holds during reset.
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe <= {STAGES{RST_VAL}};
      else        pipe <= {pipe[STAGES-2:0], d};
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/spi_serf.sv
// SPI responder: mode-3 timing, MSB first, oversampled on clk.
// Optional frame-error flag enabled by SPI_SERF_FRM_ERR_EN.
import spi_pkg::*;

module spi_serf #(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              clr_rdy,
   output logic [DATA_W-1:0] rx_data,
   output logic              rdy
`ifdef SPI_SERF_FRM_ERR_EN
   ,
   output logic              frm_err
`endif
);

   localparam int CW = cnt_w(DATA_W);
   localparam int SW = cnt_w(SYNC_STAGES);
   localparam logic [CW-1:0] FULL = CW'(DATA_W);
   localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES);

   logic ss_s, sclk_s, mosi_s;
   logic ss_q, sclk_q;
   logic ss_fall, ss_rise, sclk_rise, sclk_fall;

   serf_state_t state_q, state_d;
   logic start, frame_end, done_ok;

   logic [DATA_W-1:0] shift_reg;
   logic [CW-1:0]     bit_cnt, shf_cnt;
   logic              mosi_smpl;

   logic [SW-1:0] settle;
   logic          settle_done, armed;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
      .clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
      .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_q   <= 1'b1;
         sclk_q <= 1'b1;
      end else begin
         ss_q   <= ss_s;
         sclk_q <= sclk_s;
      end
   end

   assign ss_fall   =  ss_q   & ~ss_s;
   assign ss_rise   = ~ss_q   &  ss_s;
   assign sclk_rise = ~sclk_q &  sclk_s;
   assign sclk_fall =  sclk_q & ~sclk_s;

   // The reset value in the sync chain looks like "deselected"; a select
   // held low through reset must not be mistaken for a fresh ss_fall, so
   // frames are only accepted once SS_n has really been seen high.
   assign settle_done = (settle == SETTLED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle <= '0;
         armed  <= 1'b0;
      end else begin
         if (!settle_done)         settle <= settle + SW'(1);
         if (settle_done && ss_s) armed  <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      frame_end = 1'b0;
      MISO      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_fall && armed) begin
               state_d = SHIFT;
               start   = 1'b1;
            end
         end
         SHIFT: begin
            MISO = shift_reg[DATA_W-1];
            if (ss_rise) begin
               state_d   = IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign done_ok = frame_end && (bit_cnt == FULL) && (shf_cnt == FULL);

   // The fall before the first rise is the front porch and must not shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         shf_cnt   <= '0;
         mosi_smpl <= 1'b0;
      end else if (start) begin
         shift_reg <= tx_data;
         bit_cnt   <= '0;
         shf_cnt   <= '0;
      end else if (state_q == SHIFT) begin
         if (sclk_rise) begin
            mosi_smpl <= mosi_s;
            if (bit_cnt != FULL) bit_cnt <= bit_cnt + CW'(1);
         end
         if (sclk_fall && (bit_cnt != '0)) begin
            shift_reg <= {shift_reg[DATA_W-2:0], mosi_smpl};
            if (shf_cnt != FULL) shf_cnt <= shf_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data <= '0;
         rdy     <= 1'b0;
      end else begin
         if (done_ok) rx_data <= shift_reg;
         if (done_ok)                rdy <= 1'b1;
         else if (clr_rdy || start) rdy <= 1'b0;
      end
   end

`ifdef SPI_SERF_FRM_ERR_EN
   logic [1:0] guard;
   logic       err_set;

   // guard covers the two clk after select during which SCLK must stay quiet
   assign err_set = (frame_end && (bit_cnt != FULL)) ||
                    ((state_q == SHIFT) && sclk_rise && (guard != 2'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         guard   <= 2'd0;
         frm_err <= 1'b0;
      end else begin
         if (start)              guard <= 2'd2;
         else if (guard != 2'd0) guard <= guard - 2'd1;
         if (err_set)      frm_err <= 1'b1;
         else if (clr_rdy) frm_err <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: monarch-style pin driver, rx scoreboard.
// Build with SPI_SERF_FRM_ERR_EN defined to also cover frm_err.
module tb_spi_serf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic [15:0] tx_data = 16'h0000;
   logic        clr_rdy = 1'b0;
   logic [15:0] rx_data;
   logic        rdy;
`ifdef SPI_SERF_FRM_ERR_EN
   logic        frm_err;
`endif

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   logic        rdy_prev = 1'b0;

   always #5 clk = ~clk;

   spi_serf #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .SS_n(SS_n),
      .SCLK(SCLK),
      .MOSI(MOSI),
      .MISO(MISO),
      .tx_data(tx_data),
      .clr_rdy(clr_rdy),
      .rx_data(rx_data),
      .rdy(rdy)
`ifdef SPI_SERF_FRM_ERR_EN
      ,
      .frm_err(frm_err)
`endif
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // scoreboard monitor: every new rdy must match the oldest expected word
   always @(negedge clk) begin
      logic [15:0] e;
      if (rdy && !rdy_prev) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got %0h want none", rx_data);
         end else begin
            e = exp_q.pop_front();
            check("rx_data", {16'h0, rx_data}, {16'h0, e});
         end
      end
      rdy_prev = rdy;
   end

   task automatic hp();
      repeat (8) @(posedge clk);
      #2;
   endtask

   task automatic idle_sclk();
      hp();
      SCLK = 1'b1;
      hp();
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #2 clr_rdy = 1'b1;
      @(posedge clk);
      #2 clr_rdy = 1'b0;
   endtask

   // leaves SS_n low and SCLK low after the final shifting fall
   task automatic xfer(input logic [15:0] w, input int nr,
                       output logic [15:0] rd);
      logic [15:0] sh;
      rd = 16'h0;
      SS_n = 1'b0;
      hp();
      SCLK = 1'b0;
      MOSI = w[15];
      hp();
      for (int i = 0; i < nr; i++) begin
         rd = {rd[14:0], MISO};
         SCLK = 1'b1;
         hp();
         sh = w << (i + 1);
         SCLK = 1'b0;
         MOSI = sh[15];
         hp();
      end
   endtask

   initial begin
      logic [15:0] rd;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_miso", {31'h0, MISO}, 32'h0);
      check("rst_rdy", {31'h0, rdy}, 32'h0);
      check("rst_rx", {16'h0, rx_data}, 32'h0);
`ifdef SPI_SERF_FRM_ERR_EN
      check("rst_frm_err", {31'h0, frm_err}, 32'h0);
`endif
      @(posedge clk);
      #2 rst_n = 1'b1;
      hp();

      // T1 basic exchange and rdy latency
      tx_data = 16'hA5C3;
      exp_q.push_back(16'h1234);
      xfer(16'h1234, 16, rd);
      SS_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t1_rdy_early", {31'h0, rdy}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("t1_rdy_lat", {31'h0, rdy}, 32'h1);
      check("t1_miso_word", {16'h0, rd}, 32'hA5C3);
`ifdef SPI_SERF_FRM_ERR_EN
      check("t1_frm_err", {31'h0, frm_err}, 32'h0);
`endif
      idle_sclk();

      // T2 back-to-back frames, no clr_rdy
      tx_data = 16'h5A5A;
      exp_q.push_back(16'hFFFF);
      xfer(16'hFFFF, 16, rd);
      SS_n = 1'b1;
      idle_sclk();
      check("t2_miso_a", {16'h0, rd}, 32'h5A5A);
      exp_q.push_back(16'h0001);
      xfer(16'h0001, 16, rd);
      @(negedge clk);
      check("t2_rdy_drop", {31'h0, rdy}, 32'h0);
      check("t2_miso_b", {16'h0, rd}, 32'h5A5A);
      SS_n = 1'b1;
      idle_sclk();

      // T3 short frame is dropped
      pulse_clr();
      xfer(16'h0F0F, 9, rd);
      SS_n = 1'b1;
      idle_sclk();
      @(negedge clk);
      check("t3_rdy", {31'h0, rdy}, 32'h0);
      check("t3_rx_hold", {16'h0, rx_data}, 32'h0001);
`ifdef SPI_SERF_FRM_ERR_EN
      check("t3_frm_err", {31'h0, frm_err}, 32'h1);
      pulse_clr();
      @(negedge clk);
      check("t3_frm_clr", {31'h0, frm_err}, 32'h0);
`endif

      // T4 clr_rdy coincident with the set
      tx_data = 16'h3C96;
      exp_q.push_back(16'h6B1E);
      xfer(16'h6B1E, 16, rd);
      SS_n = 1'b1;
      repeat (2) @(posedge clk);
      #2 clr_rdy = 1'b1;
      @(posedge clk);
      #2 clr_rdy = 1'b0;
      @(negedge clk);
      check("t4_set_wins", {31'h0, rdy}, 32'h1);
      pulse_clr();
      @(negedge clk);
      check("t4_clr", {31'h0, rdy}, 32'h0);
      check("t4_miso_word", {16'h0, rd}, 32'h3C96);
      idle_sclk();

      // T5 reset mid-frame, SS_n held low across release
      tx_data = 16'hF00D;
      xfer(16'hBEEF, 8, rd);
      rst_n = 1'b0;
      #1;
      check("t5_miso", {31'h0, MISO}, 32'h0);
      check("t5_rdy", {31'h0, rdy}, 32'h0);
      check("t5_rx", {16'h0, rx_data}, 32'h0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #2 SCLK = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("t5_idle_after_rst", {31'h0, MISO}, 32'h0);
      #2 SS_n = 1'b1;
      hp();
      exp_q.push_back(16'hCAFE);
      xfer(16'hCAFE, 16, rd);
      SS_n = 1'b1;
      idle_sclk();
      check("t5_miso_word", {16'h0, rd}, 32'hF00D);

      // T6 SCLK activity while deselected
      pulse_clr();
      for (int i = 0; i < 6; i++) begin
         SCLK = ~SCLK;
         MOSI = ~MOSI;
         repeat (4) @(posedge clk);
         @(negedge clk);
         check("t6_miso", {31'h0, MISO}, 32'h0);
         #2;
      end
      check("t6_rdy", {31'h0, rdy}, 32'h0);
      check("t6_rx", {16'h0, rx_data}, 32'hCAFE);

      repeat (4) @(posedge clk);
      check("queue_empty", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
